spi_daisy_arb: RTL and testbench

SPI_DAISY_ARB -- requirements
Module: spi_daisy_arb

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_arb2.sv | 38 +++
 rtl/spi_daisy_arb.sv | 160 ++++++++++++++++
 tb/tb_spi_daisy_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI daisy-chain frame arbiter.
package spi_pkg;

   localparam int unsigned N_DEV_DEF   = 4;
   localparam int unsigned DW_DEF      = 8;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SEND,
      WAIT,
      HOLD,
      FIN
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins directly, a tie goes to the
// requester not served last (requester 0 after reset).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // Requester favoured on the next tie.
   logic prio_q, prio_d;

   always_comb begin
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      prio_d = prio_q;
      if (advance && (grant != 2'b00)) begin
         prio_d = grant[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/spi_daisy_arb.sv
// Arbitrates two frame requesters onto one byte-level SPI master and walks the
// captured frame out farthest-device-first, with a per-word m_done timeout.
module spi_daisy_arb
   import spi_pkg::*;
#(
   parameter int unsigned N_DEV   = N_DEV_DEF,
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req,
   input  logic [N_DEV*DW-1:0] req_data0,
   input  logic [N_DEV*DW-1:0] req_data1,
   output logic [1:0]          gnt,
   output logic [1:0]          done,
   output logic                err,
   output logic                m_start,
   output logic [DW-1:0]       m_data,
   input  logic                m_done,
   output logic                cs,
   output logic                busy
);

   localparam int unsigned   IW      = (N_DEV > 1) ? $clog2(N_DEV) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(N_DEV - 1);
   localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [N_DEV*DW-1:0] frame_q, frame_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                owner_q, owner_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;
   logic                m_start_q, m_start_d;
   logic [DW-1:0]       m_data_q, m_data_d;
   logic                cs_q, cs_d;
   logic                busy_q, busy_d;

   logic [1:0]          arb_grant;
   logic                take;
   logic                timeout;

   assign take    = (state_q == IDLE) && (req != 2'b00);
   // m_done on the last counted cycle wins over the timeout.
   assign timeout = (state_q == WAIT) && !m_done && (cnt_q == TO_LAST);

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (take),
      .grant   (arb_grant)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
         m_start_q <= 1'b0;
         m_data_q  <= '0;
         cs_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         m_start_q <= m_start_d;
         m_data_q  <= m_data_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      unique case (state_q)
         IDLE: begin
            if (take) begin
               state_d = SETUP;
               frame_d = arb_grant[1] ? req_data1 : req_data0;
               owner_d = arb_grant[1];
               idx_d   = IDX_TOP;
            end
         end
         SETUP: state_d = SEND;
         SEND: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            if (m_done) begin
               if (idx_q != '0) begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SEND;
               end else begin
                  state_d = HOLD;
               end
            end else if (timeout) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         HOLD:    state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered copies of values decided from the current cycle.
   always_comb begin
      gnt_d     = '0;
      done_d    = '0;
      err_d     = 1'b0;
      m_start_d = 1'b0;
      m_data_d  = m_data_q;
      cs_d      = !(state_d inside {SETUP, SEND, WAIT, HOLD});
      busy_d    = (state_d != IDLE);
      if (take) begin
         gnt_d = arb_grant;
      end
      if (state_q == SEND) begin
         m_start_d = 1'b1;
         m_data_d  = frame_q[idx_q*DW +: DW];
      end
      if (state_q == HOLD) begin
         done_d = owner_q ? 2'b10 : 2'b01;
      end
      if (timeout) begin
         err_d = 1'b1;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign err     = err_q;
   assign m_start = m_start_q;
   assign m_data  = m_data_q;
   assign cs      = cs_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_spi_daisy_arb.sv
// Self-checking bench: a 4-device instance with a short timeout and a
// 1-device instance, each driven by a small behavioural SPI master.
module tb_spi_daisy_arb;

   localparam int unsigned NDEV  = 4;
   localparam int unsigned WBITS = 8;
   localparam int unsigned TO    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst;
   logic [1:0]            req;
   logic [NDEV*WBITS-1:0] d0, d1;
   logic [1:0]            gnt, done;
   logic                  err, m_start, cs, busy;
   logic [WBITS-1:0]      m_data;
   logic                  md_m, md_s, m_done;
   assign m_done = md_m | md_s;

   spi_daisy_arb #(.N_DEV(NDEV), .DW(WBITS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data0(d0), .req_data1(d1),
      .gnt(gnt), .done(done), .err(err), .m_start(m_start), .m_data(m_data),
      .m_done(m_done), .cs(cs), .busy(busy)
   );

   logic [1:0] req_b, gnt_b, done_b;
   logic [7:0] b0, b1, mdat_b;
   logic       err_b, ms_b, mdone_b, cs_b, busy_b;

   spi_daisy_arb #(.N_DEV(1), .DW(8), .TIMEOUT(TO)) dut1 (
      .clk(clk), .rst(rst), .req(req_b), .req_data0(b0), .req_data1(b1),
      .gnt(gnt_b), .done(done_b), .err(err_b), .m_start(ms_b), .m_data(mdat_b),
      .m_done(mdone_b), .cs(cs_b), .busy(busy_b)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural master for the 4-device instance: logs each word at m_start,
   // answers m_done dly_a cycles later and watches m_data for stability.
   int unsigned      dly_a = 8;
   bit               master_en = 1'b1;
   logic [WBITS-1:0] words_a[$];
   int unsigned      mdata_viol = 0;

   initial begin : master_a
      int unsigned      pend;
      logic [WBITS-1:0] held;
      pend = 0;
      held = '0;
      md_m = 1'b0;
      forever begin
         @(negedge clk);
         md_m = 1'b0;
         if (rst !== 1'b1) begin
            pend = 0;
         end else if (pend != 0) begin
            if (m_data !== held) mdata_viol++;
            pend--;
            if (pend == 0) md_m = 1'b1;
         end else if (m_start === 1'b1) begin
            words_a.push_back(m_data);
            held = m_data;
            if (master_en) pend = dly_a - 1;
         end
      end
   end

   logic [7:0] words_b[$];

   initial begin : master_b
      int unsigned pend;
      pend = 0;
      mdone_b = 1'b0;
      forever begin
         @(negedge clk);
         mdone_b = 1'b0;
         if (rst !== 1'b1) begin
            pend = 0;
         end else if (pend != 0) begin
            pend--;
            if (pend == 0) mdone_b = 1'b1;
         end else if (ms_b === 1'b1) begin
            words_b.push_back(mdat_b);
            pend = 2;
         end
      end
   end

   int unsigned gnt_both = 0, done_cnt = 0, err_cnt = 0, cs_viol = 0;
   bit          inf = 1'b0;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (gnt === 2'b11) gnt_both++;
         if (done !== 2'b00) done_cnt++;
         if (err === 1'b1) err_cnt++;
         if (done !== 2'b00 || err === 1'b1 || busy !== 1'b1) inf = 1'b0;
         if (gnt !== 2'b00) inf = 1'b1;
         if (inf && cs !== 1'b0) cs_viol++;
      end else begin
         inf = 1'b0;
      end
   end

   // Reference: round-robin favour bit and number of frames expected to finish.
   int unsigned prio_m = 0;
   int unsigned exp_done = 0;

   task automatic do_frame(input string tag, input logic [1:0] r, input logic [1:0] r_after,
                           input int unsigned dly, input bit spur);
      int unsigned           win, cyc;
      logic [NDEV*WBITS-1:0] pay;
      logic [1:0]            oh;
      win    = (r == 2'b10) ? 1 : (r == 2'b01) ? 0 : prio_m;
      prio_m = (win == 0) ? 1 : 0;
      pay    = (win == 1) ? d1 : d0;
      oh     = (win == 1) ? 2'b10 : 2'b01;
      dly_a  = dly;
      words_a.delete();
      @(posedge clk); #1;
      if (spur) begin
         md_s = 1'b1;
         @(posedge clk); #1;
         md_s = 1'b0;
      end
      req = r;
      cyc = 0;
      while (gnt === 2'b00 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check({tag, "_gnt"}, 32'(gnt), 32'(oh));
      check({tag, "_cs_low"}, 32'(cs), 0);
      req = r_after;
      d0  = $urandom;
      d1  = $urandom;
      if (spur) md_s = 1'b1;
      @(posedge clk); #1;
      md_s = 1'b0;
      check({tag, "_mstart_t1"}, 32'(m_start), 0);
      @(posedge clk); #1;
      check({tag, "_mstart_t2"}, 32'(m_start), 1);
      check({tag, "_mdata0"}, 32'(m_data), 32'(pay[(NDEV-1)*WBITS +: WBITS]));
      cyc = 0;
      while (done === 2'b00 && err !== 1'b1 && cyc < 400) begin @(posedge clk); #1; cyc++; end
      check({tag, "_done"}, 32'(done), 32'(oh));
      check({tag, "_err"}, 32'(err), 0);
      check({tag, "_cs_fin"}, 32'(cs), 1);
      exp_done++;
      check({tag, "_nwords"}, 32'(words_a.size()), NDEV);
      for (int unsigned i = 0; i < NDEV; i++) begin
         check({tag, "_word"}, 32'(words_a[i]), 32'(pay[(NDEV-1-i)*WBITS +: WBITS]));
      end
   endtask

   initial begin
      int unsigned cyc, lowcnt;
      bit          seen;
      logic [1:0]  r;

      rst = 1'b0; req = '0; d0 = '0; d1 = '0; md_s = 1'b0;
      req_b = '0; b0 = '0; b1 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", 32'(cs), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_mstart", 32'(m_start), 0);
      check("rst_mdata", 32'(m_data), 0);
      check("rst_cs_b", 32'(cs_b), 1);
      rst = 1'b1;

      d0 = $urandom; d1 = $urandom;
      do_frame("rr0", 2'b11, 2'b11, 3, 1'b0);
      do_frame("rr1", 2'b11, 2'b11, 3, 1'b0);
      do_frame("rr2", 2'b11, 2'b00, 3, 1'b0);

      d0 = 32'hA1B2C3D4; d1 = $urandom;
      do_frame("dir", 2'b01, 2'b00, 8, 1'b1);

      for (int unsigned n = 0; n < 6; n++) begin
         d0 = $urandom; d1 = $urandom;
         r  = 2'($urandom_range(1, 3));
         do_frame("rnd", r, 2'b00, $urandom_range(2, 10), 1'($urandom_range(0, 1)));
      end

      master_en = 1'b0;
      words_a.delete();
      d0 = $urandom;
      @(posedge clk); #1;
      req    = 2'b01;
      prio_m = 1;
      cyc = 0;
      while (gnt === 2'b00 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("to_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      cyc = 0;
      while (m_start !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("to_mstart", 32'(m_start), 1);
      seen = 1'b0;
      for (int unsigned k = 1; k < TO; k++) begin
         @(posedge clk); #1;
         if (err === 1'b1 || done !== 2'b00) seen = 1'b1;
      end
      check("to_early", 32'(seen), 0);
      @(posedge clk); #1;
      check("to_err", 32'(err), 1);
      check("to_cs", 32'(cs), 1);
      check("to_busy", 32'(busy), 0);
      check("to_done", 32'(done), 0);
      @(posedge clk); #1;
      check("to_err_pulse", 32'(err), 0);
      master_en = 1'b1;

      words_a.delete();
      dly_a = 8;
      d0 = $urandom;
      @(posedge clk); #1;
      req = 2'b01;
      cyc = 0;
      while (gnt === 2'b00 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("rs_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      cyc = 0;
      while (words_a.size() < 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check("rs_words", 32'(words_a.size()), 2);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rs_cs", 32'(cs), 1);
      check("rs_busy", 32'(busy), 0);
      check("rs_done", 32'(done), 0);
      check("rs_err", 32'(err), 0);
      rst    = 1'b1;
      prio_m = 0;
      d1 = $urandom;
      do_frame("post_rst", 2'b10, 2'b00, 5, 1'b0);

      words_b.delete();
      b0 = 8'h5A; b1 = 8'($urandom);
      @(posedge clk); #1;
      req_b = 2'b01;
      cyc = 0;
      while (gnt_b === 2'b00 && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check("one_gnt", 32'(gnt_b), 32'h1);
      req_b  = 2'b00;
      lowcnt = 0;
      cyc    = 0;
      while (done_b === 2'b00 && cyc < 100) begin
         if (cs_b === 1'b0) lowcnt++;
         @(posedge clk); #1;
         cyc++;
      end
      check("one_done", 32'(done_b), 32'h1);
      check("one_err", 32'(err_b), 0);
      check("one_cs_cycles", lowcnt, 1 + 1 + 3 + 1);
      check("one_nwords", 32'(words_b.size()), 1);
      check("one_word", 32'(words_b[0]), 32'h5A);

      repeat (4) @(posedge clk);
      #1;
      check("gnt_never_both", gnt_both, 0);
      check("mdata_stable", mdata_viol, 0);
      check("cs_low_in_frame", cs_viol, 0);
      check("done_count", done_cnt, exp_done);
      check("err_count", err_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
